// File: rtl/pulp_run_ctrl.sv
// Run sequencer for the PULPino core on the emulator: holds it in reset, releases it,
// enables fetch, then waits for the end-of-operation GPIO flags or a timeout.
//
//  state      | meaning
//  -----------+--------------------------------------------------------------
//  ST_IDLE    | core held in reset, waiting for a start edge
//  ST_RESET   | core held in reset for RST_HOLD_CYCLES
//  ST_RELEASE | reset released, fetch disabled for FETCH_DELAY
//  ST_RUN     | fetch enabled, counting cycles, watching done / timeout
//  ST_DONE    | result latched, core out of reset so memory can be inspected
module pulp_run_ctrl #(
    parameter int unsigned RST_HOLD_CYCLES = 16,
    parameter int unsigned FETCH_DELAY     = 8,
    parameter int unsigned CNT_W           = 32
) (
    input  logic             ps7_clk,
    input  logic             ps7_rst_n,
    input  logic [31:0]      ctrl_i,
    input  logic [CNT_W-1:0] timeout_i,
    input  logic [31:0]      gpio_out_i,
    output logic             pulp_rst_no,
    output logic             fetch_en_o,
    output logic             busy_o,
    output logic [31:0]      status_o,
    output logic [CNT_W-1:0] cycles_o
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RESET   = 3'd1,
        ST_RELEASE = 3'd2,
        ST_RUN     = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam int unsigned TMR_MAX = (RST_HOLD_CYCLES > FETCH_DELAY) ? RST_HOLD_CYCLES : FETCH_DELAY;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] RST_LOAD   = TMR_W'(RST_HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] FETCH_LOAD = TMR_W'(FETCH_DELAY - 1);

    state_t           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic [15:0]      run_cnt_q, run_cnt_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             tmo_flag_q, tmo_flag_d;
    logic             aborted_q, aborted_d;
    logic             ctrl0_q, ctrl0_d;
    logic [1:0]       sync1_q, sync1_d;
    logic [1:0]       sync2_q, sync2_d;
    logic             pulp_rst_q, pulp_rst_d;
    logic             fetch_en_q, fetch_en_d;
    logic             busy_q, busy_d;

    logic start_edge;
    logic abort_req;
    logic done_s;
    logic pass_s;
    logic tmo_hit;
    logic unused_bits;

    assign start_edge  = ctrl_i[0] & ~ctrl0_q;
    assign abort_req   = ctrl_i[1];
    assign done_s      = sync2_q[0];
    assign pass_s      = sync2_q[1];
    assign tmo_hit     = (tmo_q != '0) && (cycles_q == (tmo_q - CNT_W'(1)));
    assign unused_bits = ^{ctrl_i[31:2], gpio_out_i[31:2]};

    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        cycles_d   = cycles_q;
        tmo_d      = tmo_q;
        run_cnt_d  = run_cnt_q;
        done_d     = done_q;
        pass_d     = pass_q;
        tmo_flag_d = tmo_flag_q;
        aborted_d  = aborted_q;
        ctrl0_d    = ctrl_i[0];
        sync1_d    = gpio_out_i[1:0];
        sync2_d    = sync1_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // abort is meaningless here, but it still swallows a coincident start
                if (start_edge && !abort_req) begin
                    state_d    = ST_RESET;
                    tmr_d      = RST_LOAD;
                    cycles_d   = '0;
                    tmo_d      = timeout_i;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                    tmo_flag_d = 1'b0;
                    aborted_d  = 1'b0;
                end
            end
            ST_RESET: begin
                if (abort_req) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                end else if (tmr_q == '0) begin
                    state_d = ST_RELEASE;
                    tmr_d   = FETCH_LOAD;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            ST_RELEASE: begin
                if (abort_req) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                end else if (tmr_q == '0) begin
                    state_d = ST_RUN;
                    if (run_cnt_q != 16'hFFFF) run_cnt_d = run_cnt_q + 16'd1;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            ST_RUN: begin
                if (abort_req) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                end else if (done_s) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    pass_d  = pass_s;
                end else begin
                    if (cycles_q != '1) cycles_d = cycles_q + CNT_W'(1);
                    if (tmo_hit) begin
                        state_d    = ST_DONE;
                        tmo_flag_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // pin outputs are registered from the next state so they line up with state_q
        pulp_rst_d = state_d inside {ST_RELEASE, ST_RUN, ST_DONE};
        fetch_en_d = (state_d == ST_RUN);
        busy_d     = state_d inside {ST_RESET, ST_RELEASE, ST_RUN};
    end

    always_ff @(posedge ps7_clk or negedge ps7_rst_n) begin
        if (!ps7_rst_n) begin
            state_q    <= ST_IDLE;
            tmr_q      <= '0;
            cycles_q   <= '0;
            tmo_q      <= '0;
            run_cnt_q  <= '0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            tmo_flag_q <= 1'b0;
            aborted_q  <= 1'b0;
            ctrl0_q    <= 1'b0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            pulp_rst_q <= 1'b0;
            fetch_en_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            cycles_q   <= cycles_d;
            tmo_q      <= tmo_d;
            run_cnt_q  <= run_cnt_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            tmo_flag_q <= tmo_flag_d;
            aborted_q  <= aborted_d;
            ctrl0_q    <= ctrl0_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            pulp_rst_q <= pulp_rst_d;
            fetch_en_q <= fetch_en_d;
            busy_q     <= busy_d;
        end
    end

    assign pulp_rst_no = pulp_rst_q;
    assign fetch_en_o  = fetch_en_q;
    assign busy_o      = busy_q;
    assign cycles_o    = cycles_q;
    assign status_o    = {run_cnt_q, 9'd0, aborted_q, tmo_flag_q, pass_q, done_q, state_q};

endmodule

// File: tb/tb_pulp_run_ctrl.sv
// Bench for pulp_run_ctrl: randomized runs checked against an event-time model
// (phase boundaries, done/timeout/abort arbitration) computed per observation cycle.
module tb_pulp_run_ctrl;

    localparam int R    = 16;
    localparam int F    = 8;
    localparam int RUN0 = R + F;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ctrl_i = '0;
    logic [31:0] tmo    = '0;
    logic [31:0] gpio   = '0;
    logic        pulp_rst_no, fetch_en_o, busy_o;
    logic [31:0] status_o, cycles_o;

    int          n_vec = 0;
    int          n_err = 0;
    int          rc    = 0;
    logic [31:0] last_status = '0;
    logic [31:0] last_cycles = '0;

    pulp_run_ctrl #(.RST_HOLD_CYCLES(R), .FETCH_DELAY(F), .CNT_W(32)) dut (
        .ps7_clk    (clk),
        .ps7_rst_n  (rst_n),
        .ctrl_i     (ctrl_i),
        .timeout_i  (tmo),
        .gpio_out_i (gpio),
        .pulp_rst_no(pulp_rst_no),
        .fetch_en_o (fetch_en_o),
        .busy_o     (busy_o),
        .status_o   (status_o),
        .cycles_o   (cycles_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h, expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Observation index j counts edges from the start edge (j=0 is the start edge itself).
    function automatic int scen_end(input int T, input int g);
        if (g >= 0 && (T == 0 || g + 2 <= T)) return RUN0 + 2 + g;
        return RUN0 + T;
    endfunction

    task automatic run_scenario(input int T, input int g, input bit ps, input int a);
        int          end_j, fin_cyc, last_j, st, rcv;
        bit          dn_win, ab, reached;
        logic [31:0] exp_st;
        logic [15:0] rc16;
        int          rc_base;
        rc_base = rc;
        end_j   = scen_end(T, g);
        dn_win  = (g >= 0 && (T == 0 || g + 2 <= T));
        fin_cyc = dn_win ? g + 1 : T;
        last_j  = ((a > 0) ? a : end_j) + 3;

        tmo    = T;
        ctrl_i = $urandom & 32'hFFFF_FFFC;
        gpio   = $urandom & 32'hFFFF_FFFC;
        step();

        for (int j = 0; j <= last_j; j++) begin
            logic [31:0] c;
            c = $urandom & 32'hFFFF_FFFC;
            if (j == 0 || j >= RUN0 - 4 || (a > 0 && j >= a)) c[0] = 1'b1;
            else c[0] = 1'($urandom_range(0, 1));
            c[1]   = (a > 0 && j == a);
            ctrl_i = c;
            gpio   = $urandom & 32'hFFFF_FFFC;
            if (g >= 0 && j >= RUN0 + g) gpio[1:0] = {ps, 1'b1};
            if (j == 1) tmo = $urandom;
            step();

            ab = (a > 0 && j >= a);
            if (ab)            st = 0;
            else if (j < R)    st = 1;
            else if (j < RUN0) st = 2;
            else if (j < end_j) st = 3;
            else               st = 4;
            reached = (j >= RUN0) && !(a > 0 && a <= RUN0);
            rcv = rc_base + (reached ? 1 : 0);
            if (rcv > 65535) rcv = 65535;
            rc16   = rcv[15:0];
            exp_st = {rc16, 9'd0, ab, (st == 4 && !dn_win), (st == 4 && dn_win && ps),
                      (st == 4 && dn_win), st[2:0]};

            chk("status", status_o, exp_st);
            chk("pulp_rst_no", pulp_rst_no, (st >= 2));
            chk("fetch_en", fetch_en_o, (st == 3));
            chk("busy", busy_o, (st >= 1 && st <= 3));
            if (st == 1 || st == 2) chk("cycles_pre", cycles_o, 0);
            else if (st == 3)       chk("cycles_run", cycles_o, j - RUN0);
            else if (st == 4) begin
                chk("cycles_done", cycles_o, fin_cyc);
                last_cycles = fin_cyc;
            end
            last_status = exp_st;
        end
        rc = rc_base + ((a > 0 && a <= RUN0) ? 0 : 1);
        if (rc > 65535) rc = 65535;
        ctrl_i = '0;
        gpio   = '0;
        step();
    endtask

    // Abort together with a start edge while idle/done: nothing may change.
    task automatic coincident(input bit cyc_known);
        ctrl_i = '0;
        step();
        ctrl_i = 32'h3;
        step();
        chk("coinc_status", status_o, last_status);
        if (cyc_known) chk("coinc_cycles", cycles_o, last_cycles);
        ctrl_i = 32'h1;
        step();
        chk("coinc_held", status_o, last_status);
        ctrl_i = '0;
        step();
        chk("coinc_after", busy_o, 1'b0);
    endtask

    initial begin
        int T, g, a;
        bit ps;

        #22;
        chk("rst_pulp", pulp_rst_no, 1'b0);
        chk("rst_fetch", fetch_en_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_status", status_o, 32'h0);
        chk("rst_cycles", cycles_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("idle_status", status_o, 32'h0);

        run_scenario(0, 101, 1'b1, -1);
        chk("plan_status", status_o, 32'h0001_001C);
        chk("plan_cycles", cycles_o, 32'd102);
        coincident(1'b1);
        run_scenario(50, -1, 1'b0, -1);
        run_scenario(0, 10, 1'b0, -1);
        run_scenario(0, 200, 1'b1, 40);
        coincident(1'b0);
        run_scenario(20, 18, 1'b1, -1);
        run_scenario(0, 5, 1'b1, 3);
        run_scenario(0, 5, 1'b1, 20);
        run_scenario(0, 5, 1'b1, RUN0);
        run_scenario(0, 5, 1'b1, RUN0 + 1);

        // asynchronous reset in the middle of RUN
        tmo    = '0;
        ctrl_i = '0;
        gpio   = '0;
        step();
        ctrl_i = 32'h1;
        repeat (RUN0 + 5) step();
        chk("pre_arst_fetch", fetch_en_o, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pulp", pulp_rst_no, 1'b0);
        chk("arst_fetch", fetch_en_o, 1'b0);
        chk("arst_busy", busy_o, 1'b0);
        chk("arst_status", status_o, 32'h0);
        chk("arst_cycles", cycles_o, 32'h0);
        @(negedge clk);
        rst_n  = 1'b1;
        ctrl_i = '0;
        rc     = 0;
        step();
        run_scenario(30, 5, 1'b1, -1);

        for (int k = 0; k < 12; k++) begin
            T  = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 60));
            g  = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 60));
            if (T == 0 && g < 0) g = int'($urandom_range(0, 60));
            ps = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, scen_end(T, g))) : -1;
            run_scenario(T, g, ps, a);
            if (k % 4 == 3) coincident(a < 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
